byte_pack_ctrl: RTL and testbench

- Sequencing controller wrapped around the existing Shifter merge datapath.
- Accepts a stream of 32-bit words, each carrying 0..4 valid bytes (MSB-aligned), and packs them back-to-back into dense 32-bit output words.
- Handles output backpressure, and flushes a partial tail word on an end-of-stream marker.
- Sits between the compressor's variable-length token emitter and the fixed-width output FIFO.

---
 rtl/byte_pack_ctrl_pkg.sv | 21 ++
 rtl/byte_pack_ctrl_if.sv | 31 +++
 rtl/byte_pack_ctrl_shifter.sv | 33 +++
 rtl/byte_pack_ctrl.sv | 138 +++++++++++++
 tb/tb_byte_pack_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/byte_pack_ctrl_pkg.sv
// byte_pack_ctrl_pkg
//   Shared constants, the controller state type and the input length clamp
//   used by the byte packer and its merge unit.
package byte_pack_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 3;
  localparam int DATA_W     = BYTE_W * WORD_BYTES;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } stateT;

  // Lengths above a full word are treated as a full word.
  function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(WORD_BYTES)) ? LEN_W'(WORD_BYTES) : len;
  endfunction

endpackage

// File: rtl/byte_pack_ctrl_if.sv
// byte_pack_ctrl_if
//   Input beat stream and packed output stream of the byte packer.
//   slave  : the packer (consumes in_*, produces out_*, samples out_ready)
//   master : the environment (produces in_*, consumes out_*)
//   in_valid/in_ready/in_data/in_len/in_last    : variable-length input beats
//   out_valid/out_ready/out_data/out_len/out_last : dense packed words
interface byte_pack_ctrl_if;
  import byte_pack_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len, out_last
  );

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_last
  );

endinterface

// File: rtl/byte_pack_ctrl_shifter.sv
// Shifter
//   Combinational merge unit. Keeps the top len1 bytes of dataIn, zeroes the
//   rest, and places them in a double-width window right after len0 bytes
//   already occupying the top of the window.
//   dataIn   : new word, valid bytes MSB-aligned
//   len0     : bytes already held ahead of the new data
//   len1     : valid bytes in dataIn (0..4)
//   dataOut  : shifted new bytes in a 2*DATA_IN_WIDTH window
//   addedLen : len0 + len1
module Shifter #(
  parameter int DATA_IN_WIDTH = 32,
  parameter int LEN_IN_WIDTH  = 3
) (
  input  logic [DATA_IN_WIDTH-1:0]   dataIn,
  input  logic [LEN_IN_WIDTH-1:0]    len0,
  input  logic [LEN_IN_WIDTH-1:0]    len1,
  output logic [2*DATA_IN_WIDTH-1:0] dataOut,
  output logic [LEN_IN_WIDTH-1:0]    addedLen
);

  logic [LEN_IN_WIDTH+2:0]  sh0, sh1;
  logic [DATA_IN_WIDTH-1:0] keepMask, masked;

  assign sh0 = {len0, 3'b000};
  assign sh1 = {len1, 3'b000};

  // A shift of a full word or more leaves zero, so len1>=4 keeps every byte.
  assign keepMask = ~({DATA_IN_WIDTH{1'b1}} >> sh1);
  assign masked   = dataIn & keepMask;
  assign dataOut  = {masked, {DATA_IN_WIDTH{1'b0}}} >> sh0;
  assign addedLen = len0 + len1;

endmodule

// File: rtl/byte_pack_ctrl.sv
// byte_pack_ctrl
//   Packs 0..4-byte MSB-aligned input beats into dense 32-bit words. Pending
//   bytes (0..3) live in acc; a single output register slice carries the
//   packed word. in_last flushes everything pending, taking one extra FLUSH
//   cycle when the tail spills past a full word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : byte_pack_ctrl_if.slave (input beats in, packed words out)
//   stat_bytes : accepted valid bytes (only with BYTE_PACK_CTRL_STATS_EN)
//   stat_words : output handshakes   (only with BYTE_PACK_CTRL_STATS_EN)
//   Optional feature macro: BYTE_PACK_CTRL_STATS_EN
module byte_pack_ctrl
  import byte_pack_ctrl_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 32,
  parameter int LEN_IN_WIDTH  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  byte_pack_ctrl_if.slave    bus
`ifdef BYTE_PACK_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_bytes,
  output logic [31:0]        stat_words
`endif
);

  localparam logic [LEN_IN_WIDTH-1:0] FULL = LEN_IN_WIDTH'(WORD_BYTES);

  stateT                      state;
  logic [DATA_IN_WIDTH-1:0]   acc;
  logic [LEN_IN_WIDTH-1:0]    cnt;
  logic                       outValid, outLast;
  logic [DATA_IN_WIDTH-1:0]   outData;
  logic [LEN_IN_WIDTH-1:0]    outLen;

  logic [LEN_IN_WIDTH-1:0]    lenIn, total;
  logic [2*DATA_IN_WIDTH-1:0] shOut, merged;
  logic                       slotFree, accept, outFire;

  assign lenIn    = clampLen(bus.in_len);
  assign slotFree = !outValid || bus.out_ready;
  assign bus.in_ready = (state == RUN) && slotFree;
  assign accept   = bus.in_valid && bus.in_ready;
  assign outFire  = outValid && bus.out_ready;

  Shifter #(
    .DATA_IN_WIDTH (DATA_IN_WIDTH),
    .LEN_IN_WIDTH  (LEN_IN_WIDTH)
  ) uShifter (
    .dataIn   (bus.in_data),
    .len0     (cnt),
    .len1     (lenIn),
    .dataOut  (shOut),
    .addedLen (total)
  );

  // acc bytes past cnt are always zero, so OR-merging is safe.
  assign merged = {acc, {DATA_IN_WIDTH{1'b0}}} | shOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      acc      <= '0;
      cnt      <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outLen   <= '0;
      outLast  <= 1'b0;
    end else begin
      if (outFire) outValid <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (!bus.in_last) begin
              if (total < FULL) begin
                acc <= merged[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH];
                cnt <= total;
              end else begin
                outValid <= 1'b1;
                outData  <= merged[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH];
                outLen   <= FULL;
                outLast  <= 1'b0;
                acc      <= merged[DATA_IN_WIDTH-1:0];
                cnt      <= total - FULL;
              end
            end else if (total <= FULL) begin
              // Zero-length tails still emit a beat so the end is signalled.
              outValid <= 1'b1;
              outData  <= merged[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH];
              outLen   <= total;
              outLast  <= 1'b1;
              acc      <= '0;
              cnt      <= '0;
            end else begin
              outValid <= 1'b1;
              outData  <= merged[2*DATA_IN_WIDTH-1:DATA_IN_WIDTH];
              outLen   <= FULL;
              outLast  <= 1'b0;
              acc      <= merged[DATA_IN_WIDTH-1:0];
              cnt      <= total - FULL;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (slotFree) begin
            outValid <= 1'b1;
            outData  <= acc;
            outLen   <= cnt;
            outLast  <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_len   = outLen;
  assign bus.out_last  = outLast;

`ifdef BYTE_PACK_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bytes <= '0;
      stat_words <= '0;
    end else begin
      if (accept)  stat_bytes <= stat_bytes + 32'(lenIn);
      if (outFire) stat_words <= stat_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_pack_ctrl.sv
module tb_byte_pack_ctrl;
  import byte_pack_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  byte_pack_ctrl_if bus ();

`ifdef BYTE_PACK_CTRL_STATS_EN
  logic [31:0] stat_bytes, stat_words;
`endif

  byte_pack_ctrl #(.DATA_IN_WIDTH(32), .LEN_IN_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BYTE_PACK_CTRL_STATS_EN
    ,
    .stat_bytes (stat_bytes),
    .stat_words (stat_words)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for in_ready, hold through the accepting
  // edge, then drop in_valid #1 after it so outputs reflect that edge.
  task automatic send(input logic [31:0] d, input logic [2:0] l, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout observed=in_ready0 expected=in_ready1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chkOut(input string tag, input logic v, input logic [31:0] d,
                        input logic [2:0] l, input logic last);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({tag, "_data"}, bus.out_data, d);
      chk({tag, "_len"},  32'(bus.out_len), 32'(l));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(last));
    end
  endtask

  initial begin
    logic [31:0] held;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  bus.out_data, 32'h0);
    chk("rst_len",   32'(bus.out_len), 32'd0);
    chk("rst_last",  32'(bus.out_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_inready", 32'(bus.in_ready), 32'd1);

    // Packing: three 3-byte beats
    send(32'hAABBCC00, 3'd3, 1'b0);
    chkOut("pk0", 1'b0, 32'h0, 3'd0, 1'b0);
    send(32'hDDEEFF00, 3'd3, 1'b0);
    chkOut("pk1", 1'b1, 32'hAABBCCDD, 3'd4, 1'b0);
    send(32'h11223300, 3'd3, 1'b0);
    chkOut("pk2", 1'b1, 32'hEEFF1122, 3'd4, 1'b0);
    chk("pk_cnt", 32'(dut.cnt), 32'd1);
    send(32'h00000000, 3'd0, 1'b1);
    chkOut("pk3", 1'b1, 32'h33000000, 3'd1, 1'b1);

    // Last flush spilling into FLUSH
    send(32'hAABBCC00, 3'd3, 1'b0);
    chkOut("lf0", 1'b0, 32'h0, 3'd0, 1'b0);
    send(32'hDDEEFF00, 3'd3, 1'b1);
    chkOut("lf1", 1'b1, 32'hAABBCCDD, 3'd4, 1'b0);
    chk("lf_inready_flush", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chkOut("lf2", 1'b1, 32'hEEFF0000, 3'd2, 1'b1);
    chk("lf_inready_run", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chkOut("lf3", 1'b0, 32'h0, 3'd0, 1'b0);

    // Backpressure
    bus.out_ready = 1'b0;
    send(32'h01020304, 3'd4, 1'b0);
    chkOut("bp0", 1'b1, 32'h01020304, 3'd4, 1'b0);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h05060708;
    bus.in_len   = 3'd4;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_inready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold", bus.out_data, held);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_inready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chkOut("bp1", 1'b1, 32'h05060708, 3'd4, 1'b0);
    @(posedge clk); #1;
    chkOut("bp2", 1'b0, 32'h0, 3'd0, 1'b0);

    // Zero / edge lengths
    send(32'hFFFFFFFF, 3'd0, 1'b0);
    chkOut("z0", 1'b0, 32'h0, 3'd0, 1'b0);
    send(32'hDEADBEEF, 3'd0, 1'b1);
    chkOut("z1", 1'b1, 32'h00000000, 3'd0, 1'b1);
    send(32'hCAFEBABE, 3'd6, 1'b1);
    chkOut("len6", 1'b1, 32'hCAFEBABE, 3'd4, 1'b1);
    send(32'h12FFFFFF, 3'd1, 1'b0);
    send(32'h34567890, 3'd7, 1'b1);
    chkOut("len7a", 1'b1, 32'h12345678, 3'd4, 1'b0);
    @(posedge clk); #1;
    chkOut("len7b", 1'b1, 32'h90000000, 3'd1, 1'b1);
    @(posedge clk); #1;

    // Reset mid-stream with 3 bytes pending
    send(32'hAABBCC00, 3'd3, 1'b0);
    chk("mr_cnt_before", 32'(dut.cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_cnt", 32'(dut.cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mr_idle", 32'(bus.out_valid), 32'd0);
    end
    send(32'h55FFFFFF, 3'd1, 1'b1);
    chkOut("mr_new", 1'b1, 32'h55000000, 3'd1, 1'b1);
    @(posedge clk); #1;

`ifdef BYTE_PACK_CTRL_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("st_rst_bytes", stat_bytes, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send(32'h01020304 + 32'(i), 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("st_bytes", stat_bytes, 32'd40);
    chk("st_words", stat_words, 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
